// File: rtl/varredura_display.sv
// varredura_display
// Scans a 4-digit packed BCD word onto a multiplexed 7-segment display,
// one digit per time slot of DIV clock cycles.
// The display is double-buffered. A loaded word waits in a hold register
// and becomes visible only at the next frame boundary, so a frame never
// mixes two words.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   bcdin      in   16  packed BCD, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   carga      in   1   load strobe, captures bcdin this cycle
//   anodos     out  4   digit enables, active-low
//   segmentos  out  7   {g,f,e,d,c,b,a}, active-low
//   quadro     out  1   one-cycle pulse at each frame start
//
// Optional build macro: BLANK_ZEROS_EN enables leading-zero blanking.
// Without it every digit is decoded as-is. Timing is the same in both builds.
module varredura_display #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcdin,
  input  logic        carga,
  output logic [3:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        quadro
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_index;
  logic [15:0]   r_hold;
  logic [15:0]   r_shadow;
  logic          r_pend;
  logic [3:0]    r_anodos;
  logic [6:0]    r_segs;
  logic          r_quadro;

  logic          w_tick;
  logic          w_boundary;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [3:0]    w_anodos;
  logic [6:0]    w_segs;

  assign w_tick     = (r_presc == PW'(DIV - 1));
  assign w_boundary = w_tick && (r_index == 2'd3);

  // Select the digit of the shown word for the current slot, decide
  // whether it is a leading zero to blank, and decode it to active-low
  // segments. Illegal BCD values show a dash.
  always_comb begin
    w_digit  = 4'd0;
    w_blank  = 1'b0;
    w_anodos = 4'b1111;
    w_segs   = 7'b1111111;
    case (r_index)
      2'd0: begin
        w_digit  = r_shadow[3:0];
        w_anodos = 4'b1110;
      end
      2'd1: begin
        w_digit  = r_shadow[7:4];
        w_anodos = 4'b1101;
        w_blank  = (r_shadow[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit  = r_shadow[11:8];
        w_anodos = 4'b1011;
        w_blank  = (r_shadow[15:8] == 8'd0);
      end
      default: begin
        w_digit  = r_shadow[15:12];
        w_anodos = 4'b0111;
        w_blank  = (r_shadow[15:12] == 4'd0);
      end
    endcase
    case (w_digit)
      4'd0:    w_segs = 7'b1000000;
      4'd1:    w_segs = 7'b1111001;
      4'd2:    w_segs = 7'b0100100;
      4'd3:    w_segs = 7'b0110000;
      4'd4:    w_segs = 7'b0011001;
      4'd5:    w_segs = 7'b0010010;
      4'd6:    w_segs = 7'b0000010;
      4'd7:    w_segs = 7'b1111000;
      4'd8:    w_segs = 7'b0000000;
      4'd9:    w_segs = 7'b0010000;
      default: w_segs = 7'b0111111;
    endcase
`ifdef BLANK_ZEROS_EN
    if (w_blank) begin
      w_segs = 7'b1111111;
    end
`endif
  end

  // Slot timing: the prescaler sets the slot length and the index steps
  // through the four digits once per slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_index <= 2'd0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_index <= r_index + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Double buffer. A load on the boundary cycle goes straight to the
  // shown word so it is not delayed by a whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold   <= 16'd0;
      r_shadow <= 16'd0;
      r_pend   <= 1'b0;
    end else begin
      if (w_boundary) begin
        if (carga) begin
          r_hold   <= bcdin;
          r_shadow <= bcdin;
        end else if (r_pend) begin
          r_shadow <= r_hold;
        end
        r_pend <= 1'b0;
      end else if (carga) begin
        r_hold <= bcdin;
        r_pend <= 1'b1;
      end
    end
  end

  // Registered outputs: anodes and segments update together from the
  // same slot, so the display never shows a half-switched digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_anodos <= 4'b1111;
      r_segs   <= 7'b1111111;
      r_quadro <= 1'b0;
    end else begin
      r_anodos <= w_anodos;
      r_segs   <= w_segs;
      r_quadro <= w_boundary;
    end
  end

  assign anodos    = r_anodos;
  assign segmentos = r_segs;
  assign quadro    = r_quadro;

endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display
// Directed bench for varredura_display with DIV=4 (slot = 4 cycles,
// frame = 16 cycles). Each table record holds the inputs for one clock
// edge and the outputs expected just after that edge.
module tb_varredura_display;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        q;
  } vec_t;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S6    = 7'b0000010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SOFF  = 7'b1111111;
`ifdef BLANK_ZEROS_EN
  localparam logic [6:0] SZ = SOFF;
`else
  localparam logic [6:0] SZ = S0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] bcdin;
  logic        carga;
  logic [3:0]  anodos;
  logic [6:0]  segmentos;
  logic        quadro;

  int compareCount;
  int mismatchCount;
  vec_t vecs[$];

  varredura_display #(.DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bcdin     (bcdin),
    .carga     (carga),
    .anodos    (anodos),
    .segmentos (segmentos),
    .quadro    (quadro)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Appends n idle cycles that all expect the same slot output.
  task automatic pushSlot(input int n, input logic [3:0] an, input logic [6:0] seg);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = 1'b0;
      v.ld  = 1'b0;
      v.bcd = 16'hBEEF;
      v.an  = an;
      v.seg = seg;
      v.q   = 1'b0;
      vecs.push_back(v);
    end
  endtask

  task automatic pushReset(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = 1'b1;
      v.ld  = 1'b0;
      v.bcd = 16'hBEEF;
      v.an  = 4'b1111;
      v.seg = SOFF;
      v.q   = 1'b0;
      vecs.push_back(v);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] bcd);
    @(negedge clk);
    reset = rst;
    carga = ld;
    bcdin = bcd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] got,
                             input logic [31:0] want);
    compareCount++;
    if (got !== want) begin
      mismatchCount++;
      $display("[TB] FAIL %s vec%0d: got %b, want %b", name, idx, got, want);
    end
  endtask

  initial begin
    int lastPulse;
    int cyc;
    bit seen;

    compareCount  = 0;
    mismatchCount = 0;
    reset = 1'b1;
    carga = 1'b0;
    bcdin = 16'h0000;

    // Three reset cycles, then k=1.. after release (vector index 2+k).
    pushReset(3);
    // k1-16: shown word 0000
    pushSlot(4, 4'b1110, S0); pushSlot(4, 4'b1101, S0);
    pushSlot(4, 4'b1011, S0); pushSlot(4, 4'b0111, S0);
    // k17-32: 1234
    pushSlot(4, 4'b1110, S4); pushSlot(4, 4'b1101, S3);
    pushSlot(4, 4'b1011, S2); pushSlot(4, 4'b0111, S1);
    // k33-48: 5678
    pushSlot(4, 4'b1110, S8); pushSlot(4, 4'b1101, S7);
    pushSlot(4, 4'b1011, S6); pushSlot(4, 4'b0111, S5);
    // k49-64: 00A0 taken by bypass
    pushSlot(4, 4'b1110, S0); pushSlot(4, 4'b1101, SDASH);
    pushSlot(4, 4'b1011, SZ); pushSlot(4, 4'b0111, SZ);
    // k65-73: 0007, then reset on k74 in the middle of slot 2
    pushSlot(4, 4'b1110, S7); pushSlot(4, 4'b1101, SZ);
    pushSlot(1, 4'b1011, SZ);
    pushReset(1);
    // j=1.. after second release (vector index 76+j): shadow is 0
    pushSlot(4, 4'b1110, S0); pushSlot(4, 4'b1101, SZ);
    pushSlot(4, 4'b1011, SZ); pushSlot(4, 4'b0111, SZ);
    // j17-32: 9090 (last of two back-to-back loads)
    pushSlot(4, 4'b1110, S0); pushSlot(4, 4'b1101, S9);
    pushSlot(4, 4'b1011, S0); pushSlot(4, 4'b0111, S9);
    pushSlot(1, 4'b1110, S0);

    vecs[2+2].ld  = 1'b1; vecs[2+2].bcd  = 16'h1234;
    vecs[2+22].ld = 1'b1; vecs[2+22].bcd = 16'h5678;
    vecs[2+48].ld = 1'b1; vecs[2+48].bcd = 16'h00A0;
    vecs[2+50].ld = 1'b1; vecs[2+50].bcd = 16'h0007;
    vecs[76+3].ld = 1'b1; vecs[76+3].bcd = 16'h1111;
    vecs[76+4].ld = 1'b1; vecs[76+4].bcd = 16'h9090;
    vecs[2+16].q = 1'b1;
    vecs[2+32].q = 1'b1;
    vecs[2+48].q = 1'b1;
    vecs[2+64].q = 1'b1;
    vecs[76+16].q = 1'b1;
    vecs[76+32].q = 1'b1;

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].bcd);
      checkOutput("anodos",    i, 32'(anodos),    32'(vecs[i].an));
      checkOutput("segmentos", i, 32'(segmentos), 32'(vecs[i].seg));
      checkOutput("quadro",    i, 32'(quadro),    32'(vecs[i].q));
    end

    // Frame period: distance between the next two quadro pulses.
    seen = 1'b0;
    lastPulse = 0;
    cyc = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      cyc++;
      if (quadro === 1'b1) begin
        seen = 1'b1;
        lastPulse = cyc;
      end
    end
    checkOutput("firstPulseSeen", 0, 32'(seen), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      cyc++;
      if (quadro === 1'b1) begin
        seen = 1'b1;
      end
    end
    checkOutput("secondPulseSeen", 0, 32'(seen), 32'd1);
    checkOutput("quadroPeriod", 0, 32'(cyc - lastPulse), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
